// File: rtl/sort_pkg.sv
// Shared definitions for the sorter frame loader: sizes, pad value, sorter
// latency, the loader FSM encoding and the frame/count types.
package sort_pkg;

  localparam int W        = 8;   // element width
  localparam int N        = 8;   // elements per frame (sorter port count)
  localparam int SORT_LAT = 2;   // sorter latency in clk cycles, >= 1
  localparam logic [W-1:0] PAD = '0;  // value loaded into unfilled slots

  localparam int CNT_W = 4;                    // frm_count width, holds 0..8
  localparam int IDX_W = $clog2(N);            // fill index width
  localparam int LAT_W = $clog2(SORT_LAT + 1); // latency counter width

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [N-1:0][W-1:0]   frame_t;  // element 0 is slot 1

  typedef enum logic [1:0] {
    IDLE,    // no frame outstanding
    WAIT,    // frame published, sorter output not yet valid
    RESULT   // sorter output valid, waiting for res_ready
  } state_t;

endpackage

// File: rtl/sort_frame_loader_if.sv
// Bus between the loader, the byte-stream producer and the sorted-result
// consumer. The slave modport is the loader; master is the outside world.
//
// Handshakes: a beat moves on a rising clk edge where s_valid && s_ready;
// a result is taken on a rising clk edge where res_valid && res_ready.
// valid must not depend on ready; s_ready and res_valid are registered.
interface sort_frame_loader_if;
  import sort_pkg::*;

  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [W-1:0] frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8;
  cnt_t         frm_count;
  logic         res_valid;
  logic         res_ready;

  modport slave (
    input  s_data, s_valid, s_last, res_ready,
    output s_ready, frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8,
           frm_count, res_valid
  );

  modport master (
    output s_data, s_valid, s_last, res_ready,
    input  s_ready, frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8,
           frm_count, res_valid
  );

endinterface

// File: rtl/frame_shadow_buf.sv
// Shadow buffer: gathers beats into a frame, pads short frames on close and
// holds the finished frame until the loader publishes it.
module frame_shadow_buf
  import sort_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic         publish,   // loader copies the shadow out this edge
  output logic         s_ready,
  output logic         full,      // complete frame waiting to be published
  output cnt_t         sh_count,
  output frame_t       shadow
);

  logic [IDX_W-1:0] idx_q;
  logic             full_q;
  logic             rdy_q;
  cnt_t             cnt_q;
  frame_t           sh_q;
  logic             accept;
  logic             close;
  logic             full_nxt;

  assign accept = s_valid && rdy_q;
  assign close  = accept && (s_last || (idx_q == IDX_W'(N - 1)));

  // Accept and publish never coincide: accept needs !full, publish needs full.
  assign full_nxt = publish ? 1'b0 : (close ? 1'b1 : full_q);

  // Fill index, shadow contents, count and the registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
    end else begin
      full_q <= full_nxt;
      rdy_q  <= !full_nxt;
      if (accept) begin
        sh_q[idx_q] <= s_data;
        if (close) begin
          for (int i = 0; i < N; i++) begin
            if (i > int'(idx_q)) sh_q[i] <= PAD;
          end
          cnt_q <= cnt_t'(idx_q) + cnt_t'(1);
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign s_ready  = rdy_q;
  assign full     = full_q;
  assign sh_count = cnt_q;
  assign shadow   = sh_q;

endmodule

// File: rtl/sort_frame_loader.sv
// Feeds the 8-input sorter: publishes complete frames from the shadow buffer
// atomically, then flags res_valid once the sorter output reflects them.
module sort_frame_loader
  import sort_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  sort_frame_loader_if.slave   bus,
  output state_t               dbg_state
);

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             publish;
  logic             sh_full;
  cnt_t             sh_count;
  frame_t           shadow;
  frame_t           frm_q;
  cnt_t             frm_cnt_q;

  frame_shadow_buf u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (bus.s_data),
    .s_valid  (bus.s_valid),
    .s_last   (bus.s_last),
    .publish  (publish),
    .s_ready  (bus.s_ready),
    .full     (sh_full),
    .sh_count (sh_count),
    .shadow   (shadow)
  );

  // State, latency counter and the published frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      frm_q     <= '0;
      frm_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (publish) begin
        frm_q     <= shadow;
        frm_cnt_q <= sh_count;
      end
    end
  end

  // Next state: publish from IDLE or on result handoff, count down the
  // sorter latency in WAIT, hold the result until it is taken.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        if (sh_full) begin
          publish = 1'b1;
          state_d = WAIT;
          lat_d   = LAT_W'(SORT_LAT - 1);
        end
      end
      WAIT: begin
        if (lat_q == '0) state_d = RESULT;
        else             lat_d   = lat_q - 1'b1;
      end
      RESULT: begin
        if (bus.res_ready) begin
          if (sh_full) begin
            publish = 1'b1;
            state_d = WAIT;
            lat_d   = LAT_W'(SORT_LAT - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.res_valid = (state_q == RESULT);
  assign bus.frm_count = frm_cnt_q;
  assign bus.frm1      = frm_q[0];
  assign bus.frm2      = frm_q[1];
  assign bus.frm3      = frm_q[2];
  assign bus.frm4      = frm_q[3];
  assign bus.frm5      = frm_q[4];
  assign bus.frm6      = frm_q[5];
  assign bus.frm7      = frm_q[6];
  assign bus.frm8      = frm_q[7];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Bench for sort_frame_loader with a behavioural 2-cycle descending sorter
// attached to frm1..frm8.
module tb_sort_frame_loader;
  import sort_pkg::*;

  localparam int FW = CNT_W + N * W;

  typedef struct packed {
    logic [3:0] n;        // beats to send
    logic       last;     // s_last on the final beat
    frame_t     data;
    cnt_t       exp_cnt;
    frame_t     exp_frm;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_frame_loader_if bus ();
  state_t dbg_state;

  sort_frame_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- sorter model ----------------
  frame_t dut_frm, sort1, sort2;

  always_comb begin
    dut_frm[0] = bus.frm1;
    dut_frm[1] = bus.frm2;
    dut_frm[2] = bus.frm3;
    dut_frm[3] = bus.frm4;
    dut_frm[4] = bus.frm5;
    dut_frm[5] = bus.frm6;
    dut_frm[6] = bus.frm7;
    dut_frm[7] = bus.frm8;
  end

  function automatic frame_t sort_desc(input frame_t f);
    frame_t r;
    logic [W-1:0] t;
    r = f;
    for (int i = 0; i < N - 1; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        if (r[j] < r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    sort1 <= dut_frm;
    sort2 <= sort_desc(sort1);
  end

  function automatic frame_t mk(input logic [W-1:0] a1, a2, a3, a4, a5, a6, a7, a8);
    frame_t f;
    f[0] = a1; f[1] = a2; f[2] = a3; f[3] = a4;
    f[4] = a5; f[5] = a6; f[6] = a7; f[7] = a8;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'($urandom_range(1, 255));
    return f;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];
  int acc_cnt = 0;
  int res_cnt = 0;
  int cyc = 0;
  int rise_q[$];
  logic rv_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor_step();
    logic [FW-1:0] e;
    if (bus.res_valid && !rv_prev) rise_q.push_back(cyc);
    rv_prev = bus.res_valid;
    cyc++;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_frame",  dut_frm, e[N*W-1:0]);
        check("sb_count",  bus.frm_count, e[FW-1:N*W]);
        check("sb_sorted", sort2, sort_desc(e[N*W-1:0]));
        res_cnt++;
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  always @(posedge clk) begin
    if (rst_n && bus.s_valid && bus.s_ready) acc_cnt <= acc_cnt + 1;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = l;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) check("s_ready_timeout", 128'd0, 128'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int n, input logic last);
    for (int i = 0; i < n; i++) send_beat(f[i], last && (i == n - 1));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  // One frame from IDLE: publish one edge after the closing beat, result
  // valid SORT_LAT edges after the publish edge.
  task automatic run_frame(input string tag, input frame_t d, input int n,
                           input logic last, input cnt_t ecnt, input frame_t efrm);
    exp_q.push_back({ecnt, efrm});
    send_frame(d, n, last);
    @(negedge clk);
    check({tag, "_frm"}, dut_frm, efrm);
    check({tag, "_cnt"}, bus.frm_count, ecnt);
    check({tag, "_rv_lo1"}, bus.res_valid, 1'b0);
    check({tag, "_s_ready"}, bus.s_ready, 1'b1);
    @(negedge clk);
    check({tag, "_rv_lo2"}, bus.res_valid, 1'b0);
    @(negedge clk);
    check({tag, "_rv_hi"}, bus.res_valid, 1'b1);
    wait_drain(50);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  frame_t fa, fb, fc, f3[3];
  int acc0, res0;

  initial begin
    vecs[0] = '{n: 4'd8, last: 1'b0, data: mk(5, 9, 1, 7, 3, 8, 2, 6),
                exp_cnt: 4'd8, exp_frm: mk(5, 9, 1, 7, 3, 8, 2, 6)};
    vecs[1] = '{n: 4'd3, last: 1'b1, data: mk(4, 10, 7, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA),
                exp_cnt: 4'd3, exp_frm: mk(4, 10, 7, 0, 0, 0, 0, 0)};
    vecs[2] = '{n: 4'd8, last: 1'b1, data: mk(1, 200, 3, 150, 5, 100, 7, 50),
                exp_cnt: 4'd8, exp_frm: mk(1, 200, 3, 150, 5, 100, 7, 50)};
    vecs[3] = '{n: 4'd2, last: 1'b1, data: mk(11, 22, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA),
                exp_cnt: 4'd2, exp_frm: mk(11, 22, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{n: 4'd1, last: 1'b1, data: mk(8'hFF, 1, 1, 1, 1, 1, 1, 1),
                exp_cnt: 4'd1, exp_frm: mk(8'hFF, 0, 0, 0, 0, 0, 0, 0)};

    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_frm",     dut_frm, '0);
    check("rst_cnt",     bus.frm_count, '0);
    check("rst_rv",      bus.res_valid, 1'b0);
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_state",   dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_rise", bus.s_ready, 1'b1);

    // table: full, short, s_last on 8th, following short, single beat
    for (int v = 0; v < 5; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].data, int'(vecs[v].n), vecs[v].last,
                vecs[v].exp_cnt, vecs[v].exp_frm);
    end

    // backpressure: A published, B parked in the shadow, beat 17 stalls
    @(posedge clk); #1 bus.res_ready = 1'b0;
    @(negedge clk);
    fa = rand_frame();
    fb = rand_frame();
    exp_q.push_back({cnt_t'(8), fa});
    exp_q.push_back({cnt_t'(8), fb});
    send_frame(fa, 8, 1'b0);
    send_frame(fb, 8, 1'b0);
    check("bp_s_ready_lo", bus.s_ready, 1'b0);
    check("bp_rv_held",    bus.res_valid, 1'b1);
    check("bp_frm_a",      dut_frm, fa);
    fc = mk(8'h5A, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back({cnt_t'(1), fc});
    bus.s_data  = 8'h5A;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b1;
    acc0 = acc_cnt;
    repeat (3) @(negedge clk);
    check("bp_stall", 128'(acc_cnt), 128'(acc0));
    check("bp_rv_still", bus.res_valid, 1'b1);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(negedge clk);   // A taken at the coming edge
    @(negedge clk);   // B published on that edge
    check("bp_rv_drop",  bus.res_valid, 1'b0);
    check("bp_frm_b",    dut_frm, fb);
    check("bp_s_ready",  bus.s_ready, 1'b1);
    @(negedge clk);
    check("bp_beat17",   128'(acc_cnt), 128'(acc0 + 1));
    check("bp_rv_lo2",   bus.res_valid, 1'b0);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(negedge clk);
    check("bp_rv_rise",  bus.res_valid, 1'b1);
    wait_drain(50);

    // mid-fill reset discards the partial frame
    send_frame(mk(8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 0, 0, 0), 5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_frm",     dut_frm, '0);
    check("mr_cnt",     bus.frm_count, '0);
    check("mr_rv",      bus.res_valid, 1'b0);
    check("mr_s_ready", bus.s_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("mr_fresh", mk(1, 2, 3, 4, 5, 6, 7, 8), 8, 1'b0, cnt_t'(8),
              mk(1, 2, 3, 4, 5, 6, 7, 8));

    // back-to-back: 24 beats, each frame takes 8 beats plus one full-stall
    // cycle, so results rise 9 cycles apart
    acc0 = acc_cnt;
    res0 = res_cnt;
    rise_q.delete();
    for (int k = 0; k < 3; k++) begin
      f3[k] = rand_frame();
      exp_q.push_back({cnt_t'(8), f3[k]});
    end
    for (int k = 0; k < 3; k++) send_frame(f3[k], 8, k == 2);
    wait_drain(60);
    check("b2b_accepted", 128'(acc_cnt - acc0), 128'd24);
    check("b2b_results",  128'(res_cnt - res0), 128'd3);
    check("b2b_rises",    128'(rise_q.size()), 128'd3);
    if (rise_q.size() == 3) begin
      check("b2b_gap1", 128'(rise_q[1] - rise_q[0]), 128'd9);
      check("b2b_gap2", 128'(rise_q[2] - rise_q[1]), 128'd9);
    end

    repeat (3) @(negedge clk);
    check("end_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
